rvx_spi_subordinate: RTL and testbench

Memory-mapped SPI subordinate (target) peripheral; the far end of the SPI link driven by the SoC's SPI manager.
- Receives sclk, mosi and cs from an external manager and returns miso.
- Exposes TX/RX byte registers on the system bus with the same request/response device interface as the other peripherals.
- Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, multi-byte transfers while cs stays low.

---
 rtl/rvx_spi_subordinate_pkg.sv | 24 ++
 rtl/rvx_spi_subordinate_sync.sv | 32 +++
 rtl/rvx_spi_subordinate.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_rvx_spi_subordinate.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_spi_subordinate_pkg.sv
// Shared definitions for the SPI subordinate: register offsets, STATUS bit
// positions, default idle byte and the transfer state encoding.
package rvx_spi_subordinate_pkg;

   localparam logic [4:0] ADDR_TX_DATA = 5'h00;
   localparam logic [4:0] ADDR_RX_DATA = 5'h04;
   localparam logic [4:0] ADDR_STATUS  = 5'h08;
   localparam logic [4:0] ADDR_CONTROL = 5'h0C;

   localparam int STAT_RX_VALID  = 0;
   localparam int STAT_TX_EMPTY  = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVERRUN   = 3;
   localparam int STAT_COUNT_LSB = 4;

   localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;
   localparam int         RX_FIFO_DEPTH     = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

endpackage

// File: rtl/rvx_spi_subordinate_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Everything resets to 0 so a chip select held low across reset produces no falling edge.
module rvx_spi_subordinate_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   prev_r;

   // Synchronizer chain plus one delayed copy of its output for edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         chain_r <= {SYNC_STAGES{1'b0}};
         prev_r  <= 1'b0;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], async_in};
         prev_r  <= chain_r[SYNC_STAGES-1];
      end
   end

   assign sync_out = chain_r[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_r;
   assign fall     = ~sync_out & prev_r;

endmodule

// File: rtl/rvx_spi_subordinate.sv
// Memory-mapped SPI subordinate, mode 0, MSB first, 8-bit frames.
// Define RVX_SPI_SUBORDINATE_RX_FIFO_EN to replace the RX register with a 4-entry FIFO.
module rvx_spi_subordinate
   import rvx_spi_subordinate_pkg::*;
#(
   parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  rw_address,
   output logic [31:0] read_data,
   input  logic        read_request,
   output logic        read_response,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_strobe,
   input  logic        write_request,
   output logic        write_response,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   output logic        miso,
   output logic        irq
);

   logic cs_sync_s, cs_rise_s, cs_fall_s;
   logic sclk_level_unused, sclk_rise_s, sclk_fall_s;
   logic mosi_sync_s, mosi_rise_unused, mosi_fall_unused;
   logic spare_unused;

   rvx_spi_subordinate_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clock(clock), .reset(reset), .async_in(cs),
      .sync_out(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s));
   rvx_spi_subordinate_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clock(clock), .reset(reset), .async_in(sclk),
      .sync_out(sclk_level_unused), .rise(sclk_rise_s), .fall(sclk_fall_s));
   rvx_spi_subordinate_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clock(clock), .reset(reset), .async_in(mosi),
      .sync_out(mosi_sync_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   assign spare_unused = ^{write_data[31:8], write_strobe[3:1]};

   spi_state_t  state_r, state_s;
   logic [7:0]  tx_buf_r, tx_buf_s;
   logic        tx_full_r, tx_full_s;
   logic [7:0]  tx_shift_r, tx_shift_s;
   logic [7:0]  rx_shift_r, rx_shift_s;
   logic [2:0]  bit_cnt_r, bit_cnt_s;
   logic        rx_valid_r, rx_valid_s;
   logic        overrun_r, overrun_s;
   logic        irq_en_r, irq_en_s;
   logic        irq_r, irq_s;
   logic        miso_r, miso_s;
   logic [31:0] read_data_r, read_data_s;
   logic        rd_resp_r, rd_resp_s;
   logic        wr_resp_r, wr_resp_s;

   logic        tx_write_s, rx_read_s, byte_done_s, load_s;
   logic [7:0]  byte_s, load_byte_s, rx_out_s;
   logic [2:0]  count_field_s;

`ifdef RVX_SPI_SUBORDINATE_RX_FIFO_EN
   logic [7:0]  fifo_r [RX_FIFO_DEPTH];
   logic [7:0]  fifo_s [RX_FIFO_DEPTH];
   logic [1:0]  rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
   logic [2:0]  count_r, count_s;
   logic        push_s, pop_s;
`else
   logic [7:0]  rx_data_r, rx_data_s;
`endif

   // Next-state logic for the transfer FSM, shifters, registers and bus responses
   always_comb begin
      state_s     = state_r;
      tx_buf_s    = tx_buf_r;
      tx_full_s   = tx_full_r;
      tx_shift_s  = tx_shift_r;
      rx_shift_s  = rx_shift_r;
      bit_cnt_s   = bit_cnt_r;
      rx_valid_s  = rx_valid_r;
      overrun_s   = overrun_r;
      irq_en_s    = irq_en_r;
      read_data_s = read_data_r;
      byte_done_s = 1'b0;
      load_s      = 1'b0;
      byte_s      = {rx_shift_r[6:0], mosi_sync_s};
      load_byte_s = tx_full_r ? tx_buf_r : IDLE_BYTE;
      tx_write_s  = write_request & write_strobe[0] & (rw_address == ADDR_TX_DATA);
      rx_read_s   = read_request & (rw_address == ADDR_RX_DATA);
      rd_resp_s   = read_request;
      wr_resp_s   = write_request;
      irq_s       = irq_en_r & rx_valid_r;

      case (state_r)
         ST_IDLE: begin
            bit_cnt_s = 3'd0;
            if (cs_fall_s) begin
               state_s = ST_ACTIVE;
               load_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise_s) begin
               state_s   = ST_IDLE;
               bit_cnt_s = 3'd0;
            end else if (sclk_rise_s) begin
               rx_shift_s  = byte_s;
               bit_cnt_s   = bit_cnt_r + 3'd1;
               byte_done_s = (bit_cnt_r == 3'd7);
            end else if (sclk_fall_s) begin
               // A falling edge with the counter at 0 follows a completed byte
               if (bit_cnt_r == 3'd0) begin
                  load_s = 1'b1;
               end else begin
                  tx_shift_s = {tx_shift_r[6:0], 1'b0};
               end
            end else begin
               state_s = ST_ACTIVE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
         end
      endcase

      if (load_s) begin
         tx_shift_s = load_byte_s;
         tx_full_s  = 1'b0;
      end else begin
         tx_full_s  = tx_full_r;
      end

      // A write landing with a reload still sets tx_full: the reload took the old byte
      if (tx_write_s) begin
         tx_buf_s  = write_data[7:0];
         tx_full_s = 1'b1;
      end else begin
         tx_buf_s  = tx_buf_r;
      end

      if (write_request && write_strobe[0] && (rw_address == ADDR_CONTROL)) begin
         irq_en_s = write_data[0];
      end else begin
         irq_en_s = irq_en_r;
      end

      miso_s = (state_s == ST_ACTIVE) ? tx_shift_s[7] : 1'b0;

`ifdef RVX_SPI_SUBORDINATE_RX_FIFO_EN
      fifo_s   = fifo_r;
      rd_ptr_s = rd_ptr_r;
      wr_ptr_s = wr_ptr_r;
      pop_s    = rx_read_s && (count_r != 3'd0);
      push_s   = byte_done_s && ((count_r != 3'd4) || pop_s);
      rx_out_s = (count_r != 3'd0) ? fifo_r[rd_ptr_r] : 8'h00;
      if (rx_read_s) begin
         overrun_s = 1'b0;
      end else begin
         overrun_s = overrun_r;
      end
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r + 2'd1;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      if (push_s) begin
         fifo_s[wr_ptr_r] = byte_s;
         wr_ptr_s         = wr_ptr_r + 2'd1;
      end else if (byte_done_s) begin
         overrun_s = 1'b1;
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      count_s       = count_r + {2'b00, push_s} - {2'b00, pop_s};
      rx_valid_s    = (count_s != 3'd0);
      count_field_s = count_r;
`else
      rx_data_s = rx_data_r;
      rx_out_s  = rx_data_r;
      if (rx_read_s) begin
         rx_valid_s = 1'b0;
         overrun_s  = 1'b0;
      end else begin
         rx_valid_s = rx_valid_r;
      end
      // A read in the completion cycle already returned the old byte, so no overrun
      if (byte_done_s) begin
         rx_data_s  = byte_s;
         rx_valid_s = 1'b1;
         if (rx_valid_r && !rx_read_s) begin
            overrun_s = 1'b1;
         end else begin
            overrun_s = overrun_s;
         end
      end else begin
         rx_data_s = rx_data_r;
      end
      count_field_s = 3'd0;
`endif

      if (read_request) begin
         case (rw_address)
            ADDR_TX_DATA: read_data_s = {24'd0, tx_buf_r};
            ADDR_RX_DATA: read_data_s = {24'd0, rx_out_s};
            ADDR_STATUS: begin
               read_data_s = 32'd0;
               read_data_s[STAT_RX_VALID] = rx_valid_r;
               read_data_s[STAT_TX_EMPTY] = ~tx_full_r;
               read_data_s[STAT_BUSY]     = ~cs_sync_s;
               read_data_s[STAT_OVERRUN]  = overrun_r;
               read_data_s[STAT_COUNT_LSB +: 3] = count_field_s;
            end
            ADDR_CONTROL: read_data_s = {31'd0, irq_en_r};
            default:      read_data_s = 32'd0;
         endcase
      end else begin
         read_data_s = read_data_r;
      end
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         tx_buf_r    <= 8'h00;
         tx_full_r   <= 1'b0;
         tx_shift_r  <= 8'h00;
         rx_shift_r  <= 8'h00;
         bit_cnt_r   <= 3'd0;
         rx_valid_r  <= 1'b0;
         overrun_r   <= 1'b0;
         irq_en_r    <= 1'b0;
         irq_r       <= 1'b0;
         miso_r      <= 1'b0;
         read_data_r <= 32'd0;
         rd_resp_r   <= 1'b0;
         wr_resp_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         tx_buf_r    <= tx_buf_s;
         tx_full_r   <= tx_full_s;
         tx_shift_r  <= tx_shift_s;
         rx_shift_r  <= rx_shift_s;
         bit_cnt_r   <= bit_cnt_s;
         rx_valid_r  <= rx_valid_s;
         overrun_r   <= overrun_s;
         irq_en_r    <= irq_en_s;
         irq_r       <= irq_s;
         miso_r      <= miso_s;
         read_data_r <= read_data_s;
         rd_resp_r   <= rd_resp_s;
         wr_resp_r   <= wr_resp_s;
      end
   end

`ifdef RVX_SPI_SUBORDINATE_RX_FIFO_EN
   // Receive FIFO storage and pointers
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
            fifo_r[i] <= 8'h00;
         end
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else begin
         fifo_r   <= fifo_s;
         rd_ptr_r <= rd_ptr_s;
         wr_ptr_r <= wr_ptr_s;
         count_r  <= count_s;
      end
   end
`else
   // Single receive data register
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_data_r <= 8'h00;
      end else begin
         rx_data_r <= rx_data_s;
      end
   end
`endif

   assign read_data      = read_data_r;
   assign read_response  = rd_resp_r;
   assign write_response = wr_resp_r;
   assign miso           = miso_r;
   assign irq            = irq_r;

endmodule

// File: tb/tb_rvx_spi_subordinate.sv
// Directed bench for rvx_spi_subordinate: bus reads go through a scoreboard queue
// checked by a monitor on read_response; SPI and level outputs are checked directly.
module tb_rvx_spi_subordinate;

   localparam logic [4:0] A_TX   = 5'h00;
   localparam logic [4:0] A_RX   = 5'h04;
   localparam logic [4:0] A_STAT = 5'h08;
   localparam logic [4:0] A_CTRL = 5'h0C;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;
   logic        write_response;
   logic        sclk, mosi, cs;
   logic        miso, irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   string       name_q [$];
   logic [7:0]  mi;

   always #5 clock = ~clock;

   rvx_spi_subordinate dut (
      .clock(clock), .reset(reset), .rw_address(rw_address), .read_data(read_data),
      .read_request(read_request), .read_response(read_response),
      .write_data(write_data), .write_strobe(write_strobe),
      .write_request(write_request), .write_response(write_response),
      .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso), .irq(irq));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read response pops one expected value
   always @(negedge clock) begin
      if (read_response === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read_response: got data 0x%0h, expected no response", read_data);
         end else begin
            check(name_q.pop_front(), read_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string name);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clock);
      #1;
      rw_address   = a;
      read_request = 1'b1;
      @(posedge clock);
      #1;
      read_request = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      @(posedge clock);
      #1;
      rw_address    = a;
      write_data    = d;
      write_strobe  = 4'h1;
      write_request = 1'b1;
      @(posedge clock);
      #1;
      write_request = 1'b0;
      check("write_response", {31'd0, write_response}, 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic set_cs(input logic v);
      cs = v;
      wait_clk(6);
   endtask

   // Mode-0 manager: data changes while sclk low, miso sampled just before the rising edge
   task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         wait_clk(4);
         rx[7-i] = miso;
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(4);
   endtask

   initial begin
      reset = 1'b1; rw_address = 5'd0; read_request = 1'b0; write_data = 32'd0;
      write_strobe = 4'h0; write_request = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      check("reset_miso", {31'd0, miso}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_read_data", read_data, 32'd0);
      check("reset_responses", {30'd0, read_response, write_response}, 32'd0);
      wait_clk(6);
      bus_read(A_STAT, 32'h2, "reset_status");

      // Queued TX byte shifted out while a byte is received
      bus_write(A_TX, 32'hA5);
      bus_read(A_TX, 32'hA5, "tx_readback");
      bus_read(A_STAT, 32'h0, "status_tx_full");
      set_cs(1'b0);
      spi_xfer(8'h3C, 8, mi);
      set_cs(1'b1);
      check("t1_miso", {24'd0, mi}, 32'hA5);
      check("t1_miso_idle", {31'd0, miso}, 32'd0);
      bus_read(A_STAT, 32'h3, "t1_status");
      bus_read(A_RX, 32'h3C, "t1_rx");
      bus_read(A_STAT, 32'h2, "t1_status_after_read");

      // Two bytes without reading: idle bytes out, overrun in the single-register build
      set_cs(1'b0);
      spi_xfer(8'h01, 8, mi);
      check("t2_miso0", {24'd0, mi}, 32'hFF);
      spi_xfer(8'h02, 8, mi);
      check("t2_miso1", {24'd0, mi}, 32'hFF);
      set_cs(1'b1);
`ifdef RVX_SPI_SUBORDINATE_RX_FIFO_EN
      bus_read(A_STAT, 32'h23, "t2_status");
      bus_read(A_RX, 32'h01, "t2_rx0");
      bus_read(A_RX, 32'h02, "t2_rx1");
`else
      bus_read(A_STAT, 32'hB, "t2_status");
      bus_read(A_RX, 32'h02, "t2_rx");
`endif
      bus_read(A_STAT, 32'h2, "t2_status_cleared");

      // Interrupt follows rx_valid when enabled
      bus_write(A_CTRL, 32'h1);
      bus_read(A_CTRL, 32'h1, "t3_control");
      check("t3_irq_before", {31'd0, irq}, 32'd0);
      set_cs(1'b0);
      spi_xfer(8'h55, 8, mi);
      set_cs(1'b1);
      check("t3_irq_set", {31'd0, irq}, 32'd1);
      bus_read(A_RX, 32'h55, "t3_rx");
      check("t3_irq_clear", {31'd0, irq}, 32'd0);
      bus_write(A_CTRL, 32'h0);

      // Partial frame discarded, next frame aligned
      set_cs(1'b0);
      spi_xfer(8'hAA, 5, mi);
      set_cs(1'b1);
      bus_read(A_STAT, 32'h2, "t4_status_partial");
      set_cs(1'b0);
      spi_xfer(8'h81, 8, mi);
      set_cs(1'b1);
      check("t4_miso", {24'd0, mi}, 32'hFF);
      bus_read(A_RX, 32'h81, "t4_rx");

      // Overwritten TX byte, then idle byte on the following frame
      bus_write(A_TX, 32'h11);
      bus_write(A_TX, 32'h22);
      set_cs(1'b0);
      spi_xfer(8'h00, 8, mi);
      check("t6_miso0", {24'd0, mi}, 32'h22);
      spi_xfer(8'h00, 8, mi);
      check("t6_miso1", {24'd0, mi}, 32'hFF);
      set_cs(1'b1);
      bus_read(A_RX, 32'h00, "t6_rx0");
      bus_read(A_RX, 32'h00, "t6_rx1");
      bus_read(A_STAT, 32'h2, "t6_status");

      // Reset mid-frame with cs held low
      bus_write(A_TX, 32'h5A);
      set_cs(1'b0);
      spi_xfer(8'hC3, 4, mi);
      reset = 1'b1;
      wait_clk(2);
      check("t5_reset_miso", {31'd0, miso}, 32'd0);
      check("t5_reset_read_data", read_data, 32'd0);
      check("t5_reset_irq", {31'd0, irq}, 32'd0);
      reset = 1'b0;
      wait_clk(2);
      spi_xfer(8'hF0, 4, mi);
      spi_xfer(8'h96, 8, mi);
      check("t5_miso_held_idle", {24'd0, mi}, 32'h00);
      set_cs(1'b1);
      bus_read(A_STAT, 32'h2, "t5_status_nothing_captured");
      set_cs(1'b0);
      spi_xfer(8'h7E, 8, mi);
      set_cs(1'b1);
      check("t5_miso_after", {24'd0, mi}, 32'hFF);
      bus_read(A_RX, 32'h7E, "t5_rx");

`ifdef RVX_SPI_SUBORDINATE_RX_FIFO_EN
      set_cs(1'b0);
      for (int b = 0; b < 5; b++) begin
         spi_xfer(8'h10 + 8'(b), 8, mi);
      end
      set_cs(1'b1);
      bus_read(A_STAT, 32'h4B, "fifo_status_full");
      for (int b = 0; b < 4; b++) begin
         bus_read(A_RX, 32'h10 + 32'(b), "fifo_rx");
      end
      bus_read(A_STAT, 32'h2, "fifo_status_empty");
`endif

      wait_clk(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_read_responses: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
